// File: rtl/riscv_pkg.sv
// Shared types and defaults for the RISC-V front end.
package riscv_pkg;

    localparam int DATA_BUS_WIDTH = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous fetch buffer: flush clears it outright, and a push into a full buffer
// succeeds only together with a pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC and the RUN/HALT state, reads instruction memory
// combinationally and queues {pc, instr} pairs for decode.
module instr_fetch
    import riscv_pkg::fetch_state_t;
    import riscv_pkg::RUN;
    import riscv_pkg::HALT;
#(
    parameter int DATA_BUS_WIDTH = riscv_pkg::DATA_BUS_WIDTH,
    parameter int MEM_SIZE = 1024,
    parameter logic [DATA_BUS_WIDTH-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int BUF_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [DATA_BUS_WIDTH-1:0] imem_addr,
    input  logic [DATA_BUS_WIDTH-1:0] imem_rdata,
    output logic                      imem_wr,
    output logic [DATA_BUS_WIDTH-1:0] imem_wdata,
    input  logic                      redirect_valid,
    input  logic [DATA_BUS_WIDTH-1:0] redirect_pc,
    output logic                      if_valid,
    input  logic                      if_ready,
    output logic [DATA_BUS_WIDTH-1:0] if_instr,
    output logic [DATA_BUS_WIDTH-1:0] if_pc,
    output logic                      fetch_err
);

    localparam int IMEM_AW = $clog2(MEM_SIZE);
    localparam int ENTRY_W = 2 * DATA_BUS_WIDTH;
    localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;

    fetch_state_t              state_q, state_d;
    logic [DATA_BUS_WIDTH-1:0] pc_q, pc_d;
    logic                      pop;
    logic                      fetch_en;
    logic [ENTRY_W-1:0]        fifo_dout;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;

    // Handshake: an entry moves to decode on a cycle where if_valid and if_ready are
    // both high; if_pc/if_instr hold steady while if_valid is high and if_ready is low,
    // and a redirect in the same cycle cancels the transfer.
    assign pop      = if_valid & if_ready;
    assign fetch_en = (state_q == RUN) & (~fifo_full | pop) & ~redirect_valid;

    assign imem_addr  = DATA_BUS_WIDTH'(pc_q[IMEM_AW+1:2]);
    assign imem_wr    = 1'b0;
    assign imem_wdata = '0;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fetch_en),
        .pop   (pop & ~redirect_valid),
        .flush (redirect_valid),
        .din   ({pc_q, imem_rdata}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[DATA_BUS_WIDTH-1:2], 2'b00};
            // Only an aligned target can leave HALT; a misaligned one parks the stage.
            state_d = (redirect_pc[1:0] == 2'b00) ? RUN : HALT;
        end else if (fetch_en) begin
            pc_d = pc_q + DATA_BUS_WIDTH'(4);
        end
    end

    always_comb begin
        fetch_err = (state_q == HALT);
        if_valid  = (fifo_count != '0);
        // Popped slots keep stale data, so the head is masked to zero when empty.
        if_pc     = fifo_empty ? '0 : fifo_dout[ENTRY_W-1:DATA_BUS_WIDTH];
        if_instr  = fifo_empty ? '0 : fifo_dout[DATA_BUS_WIDTH-1:0];
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model, fixed stimulus, one checking task.
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic [W-1:0] imem_addr;
    logic [W-1:0] imem_rdata;
    logic         imem_wr;
    logic [W-1:0] imem_wdata;
    logic         redirect_valid;
    logic [W-1:0] redirect_pc;
    logic         if_valid;
    logic         if_ready;
    logic [W-1:0] if_instr;
    logic [W-1:0] if_pc;
    logic         fetch_err;

    logic [W-1:0] imem [0:1023];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp_pc;
    int           n_checks;
    int           n_errors;

    instr_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_wr        (imem_wr),
        .imem_wdata     (imem_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_err      (fetch_err)
    );

    assign imem_rdata = (imem_addr < 1024) ? imem[imem_addr[9:0]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [W-1:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 1024; i++) imem[i] = 32'hA000_0000 | i;
        imem[0] = NOP;
        imem[1] = 32'h0010_0093;
        imem[2] = 32'h0020_0113;
        imem[3] = 32'h0030_0193;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        #3;
        check_eq("rst_valid", if_valid, 1'b0);
        check_eq("rst_pc", if_pc, '0);
        check_eq("rst_instr", if_instr, '0);
        check_eq("rst_err", fetch_err, 1'b0);
        check_eq("rst_addr", imem_addr, '0);
        step();
        step();
        reset = 1'b0;
        check_eq("imem_wr", imem_wr, 1'b0);
        check_eq("imem_wdata", imem_wdata, '0);

        // Streaming with decode always ready.
        step();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        while (exp_q.size() > 0) begin
            exp_pc = exp_q.pop_front();
            check_eq("stream_valid", if_valid, 1'b1);
            check_eq("stream_pc", if_pc, exp_pc);
            check_eq("stream_instr", if_instr, imem[exp_pc[11:2]]);
            step();
        end

        // Backpressure: buffer fills and the PC stalls at 8.
        reset = 1'b1;
        #1;
        reset    = 1'b0;
        if_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_instr", if_instr, NOP);
            check_eq("stall_pc", if_pc, 32'h0);
            step();
        end
        check_eq("stall_addr", imem_addr, 32'd2);
        if_ready = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8};
        while (exp_q.size() > 0) begin
            exp_pc = exp_q.pop_front();
            check_eq("drain_pc", if_pc, exp_pc);
            check_eq("drain_instr", if_instr, imem[exp_pc[11:2]]);
            step();
        end

        // Redirect while full flushes stale entries.
        if_ready = 1'b0;
        redirect(32'h40);
        check_eq("redir_flush_valid", if_valid, 1'b0);
        check_eq("redir_addr", imem_addr, 32'd16);
        step();
        check_eq("redir_valid", if_valid, 1'b1);
        check_eq("redir_pc", if_pc, 32'h40);
        check_eq("redir_instr", if_instr, imem[16]);

        // Misaligned target halts; only an aligned redirect resumes.
        if_ready = 1'b1;
        redirect(32'h42);
        check_eq("halt_err", fetch_err, 1'b1);
        check_eq("halt_addr", imem_addr, 32'd16);
        for (int i = 0; i < 10; i++) begin
            check_eq("halt_valid", if_valid, 1'b0);
            step();
        end
        redirect(32'h47);
        check_eq("halt_mis_err", fetch_err, 1'b1);
        check_eq("halt_mis_addr", imem_addr, 32'd17);
        check_eq("halt_mis_valid", if_valid, 1'b0);
        redirect(32'h80);
        check_eq("resume_err", fetch_err, 1'b0);
        check_eq("resume_flush", if_valid, 1'b0);
        step();
        check_eq("resume_valid", if_valid, 1'b1);
        check_eq("resume_pc", if_pc, 32'h80);
        check_eq("resume_instr", if_instr, imem[32]);

        // PC and memory index wrap.
        redirect(32'hFFFF_FFFC);
        check_eq("wrap_addr_hi", imem_addr, 32'd1023);
        check_eq("wrap_flush", if_valid, 1'b0);
        step();
        check_eq("wrap_pc_hi", if_pc, 32'hFFFF_FFFC);
        check_eq("wrap_instr_hi", if_instr, imem[1023]);
        check_eq("wrap_addr_lo", imem_addr, 32'd0);
        step();
        check_eq("wrap_pc_lo", if_pc, 32'h0);
        check_eq("wrap_instr_lo", if_instr, imem[0]);

        // Asynchronous reset between edges with entries buffered.
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_valid", if_valid, 1'b0);
        check_eq("async_pc", if_pc, '0);
        check_eq("async_addr", imem_addr, '0);
        step();
        reset = 1'b0;
        redirect(32'h42);
        check_eq("pre_rst_err", fetch_err, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_err", fetch_err, 1'b0);
        check_eq("async_addr2", imem_addr, '0);
        step();
        reset = 1'b0;
        step();
        check_eq("post_rst_valid", if_valid, 1'b1);
        check_eq("post_rst_pc", if_pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
